// File: rtl/extender_pkg.sv
// ----------------------------------------------------------------------------
// extender_pkg
// Shared types for the load-data extractor: access-size encoding, a helper
// returning the byte count of a size, and a request record wide enough for
// the largest supported bus (64 bits, 3-bit byte offset).
// ----------------------------------------------------------------------------
package extender_pkg;

    localparam int MAX_DW    = 64;
    localparam int MAX_OFF_W = 3;

    typedef enum logic [1:0] {
        EXT_B = 2'd0,
        EXT_H = 2'd1,
        EXT_W = 2'd2,
        EXT_D = 2'd3
    } ext_size_e;

    typedef struct packed {
        logic [MAX_DW-1:0]    word;
        logic [MAX_OFF_W-1:0] offset;
        ext_size_e            size;
        logic                 is_unsigned;
    } ext_req_t;

    // 1, 2, 4 or 8 bytes.
    function automatic logic [3:0] size_bytes(ext_size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/field_extender.sv
// ----------------------------------------------------------------------------
// field_extender
// Combinational field select + sign/zero extension + misalign detection.
// Ports:
//   word_i        raw aligned memory word
//   offset_i      byte offset of the field's LSB
//   size_i        ext_size_e encoding (B/H/W/D)
//   is_unsigned_i 1 = zero-extend, 0 = sign-extend
//   data_o        extended field, 0 when misaligned/illegal
//   misalign_o    offset not a multiple of size, or size wider than the bus
// ----------------------------------------------------------------------------
module field_extender #(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [OFF_W-1:0]      offset_i,
    input  logic [1:0]            size_i,
    input  logic                  is_unsigned_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  misalign_o
);
    import extender_pkg::*;

    ext_size_e             size;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] extended;
    logic [6:0]            field_bits;
    logic                  sign_bit;
    logic                  fill_bit;
    logic                  size_illegal;
    logic                  off_misalign;

    assign size       = ext_size_e'(size_i);
    // Bring the field down to bit 0; everything above it is replaced below.
    assign shifted    = word_i >> {offset_i, 3'b000};
    assign field_bits = {size_bytes(size), 3'b000};

    always_comb begin
        sign_bit = 1'b0;
        case (size)
            EXT_B:   sign_bit = shifted[7];
            EXT_H:   sign_bit = shifted[15];
            EXT_W:   sign_bit = shifted[31];
            default: sign_bit = shifted[DATA_WIDTH-1];
        endcase
    end

    assign fill_bit = sign_bit & ~is_unsigned_i;

    genvar gi;
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_ext
        assign extended[gi] = (7'(gi) < field_bits) ? shifted[gi] : fill_bit;
    end

    // A doubleword cannot be carried on a 32-bit bus.
    assign size_illegal = (DATA_WIDTH == 32) && (size == EXT_D);
    assign off_misalign = |(4'(offset_i) & (size_bytes(size) - 4'd1));
    assign misalign_o   = size_illegal | off_misalign;
    assign data_o       = misalign_o ? '0 : extended;

endmodule

// File: rtl/load_extend_pipe.sv
// ----------------------------------------------------------------------------
// load_extend_pipe
// One-stage pipelined load-data extractor with a 1-entry skid buffer.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          request handshake (in_ready = skid not full)
//   in_word/in_offset/in_size/in_unsigned   request payload
//   out_valid/out_ready        result handshake
//   out_data/out_misalign      extended result and misalign flag
//   err_count                  saturating count of accepted misaligned requests
// ----------------------------------------------------------------------------
module load_extend_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = $clog2(DATA_WIDTH / 8),
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_word,
    input  logic [OFF_W-1:0]      in_offset,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_misalign,
    output logic [ERR_CNT_W-1:0]  err_count
);
    import extender_pkg::*;

    logic [DATA_WIDTH-1:0] ext_data;
    logic                  ext_misalign;
    logic                  accept;

    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  out_mis_q,   out_mis_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  skid_mis_q,  skid_mis_d;
    logic                  skid_full_q, skid_full_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

    // Extension happens ahead of the register, so both entries hold results.
    field_extender #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFF_W      (OFF_W)
    ) u_field_extender (
        .word_i        (in_word),
        .offset_i      (in_offset),
        .size_i        (in_size),
        .is_unsigned_i (in_unsigned),
        .data_o        (ext_data),
        .misalign_o    (ext_misalign)
    );

    assign accept = in_valid && !skid_full_q;

    always_comb begin
        out_data_d  = out_data_q;
        out_mis_d   = out_mis_q;
        out_valid_d = out_valid_q;
        skid_data_d = skid_data_q;
        skid_mis_d  = skid_mis_q;
        skid_full_d = skid_full_q;
        err_count_d = err_count_q;

        if (!out_valid_q || out_ready) begin
            // Output register is free or leaving this cycle; oldest entry wins.
            if (skid_full_q) begin
                out_data_d  = skid_data_q;
                out_mis_d   = skid_mis_q;
                out_valid_d = 1'b1;
                skid_full_d = accept;
                if (accept) begin
                    skid_data_d = ext_data;
                    skid_mis_d  = ext_misalign;
                end
            end else if (accept) begin
                out_data_d  = ext_data;
                out_mis_d   = ext_misalign;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new result in the skid entry.
            skid_data_d = ext_data;
            skid_mis_d  = ext_misalign;
            skid_full_d = 1'b1;
        end

        if (accept && ext_misalign && !(&err_count_q)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_mis_q   <= 1'b0;
            out_valid_q <= 1'b0;
            skid_data_q <= '0;
            skid_mis_q  <= 1'b0;
            skid_full_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_mis_q   <= out_mis_d;
            out_valid_q <= out_valid_d;
            skid_data_q <= skid_data_d;
            skid_mis_q  <= skid_mis_d;
            skid_full_q <= skid_full_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready     = !skid_full_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_misalign = out_mis_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_load_extend_pipe.sv
// ----------------------------------------------------------------------------
// tb_load_extend_pipe
// Drives a 32-bit and a 64-bit instance of load_extend_pipe and compares their
// outputs with an arithmetic reference model of the load-extension rules.
// ----------------------------------------------------------------------------
module tb_load_extend_pipe;
    import extender_pkg::*;

    logic clk = 1'b0;
    logic reset;

    logic        a_in_valid, a_in_ready, a_in_unsigned, a_out_valid, a_out_ready, a_out_misalign;
    logic [31:0] a_in_word, a_out_data;
    logic [1:0]  a_in_offset, a_in_size;
    logic [7:0]  a_err_count;

    logic        b_in_valid, b_in_ready, b_in_unsigned, b_out_valid, b_out_ready, b_out_misalign;
    logic [63:0] b_in_word, b_out_data;
    logic [2:0]  b_in_offset;
    logic [1:0]  b_in_size;
    logic [7:0]  b_err_count;

    int checks = 0;
    int passes = 0;
    int a_err_model = 0;

    always #5 clk = ~clk;

    load_extend_pipe #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_word(a_in_word),
        .in_offset(a_in_offset), .in_size(a_in_size), .in_unsigned(a_in_unsigned),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_misalign(a_out_misalign), .err_count(a_err_count)
    );

    load_extend_pipe #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_word(b_in_word),
        .in_offset(b_in_offset), .in_size(b_in_size), .in_unsigned(b_in_unsigned),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_misalign(b_out_misalign), .err_count(b_err_count)
    );

    // Reference model: {misalign, 64-bit result} from plain arithmetic.
    function automatic logic [64:0] ref_ext(input ext_req_t r, input int dw);
        longint unsigned w, f, mask;
        int nb, fb, off;
        nb  = 1 << int'(r.size);
        fb  = 8 * nb;
        off = int'(r.offset);
        if ((dw == 32 && nb == 8) || (off % nb) != 0) return {1'b1, 64'd0};
        w = r.word;
        if (dw == 32) w &= 64'h0000_0000_FFFF_FFFF;
        f    = w >> (8 * off);
        mask = (fb == 64) ? ~64'd0 : ((64'd1 << fb) - 64'd1);
        f &= mask;
        if (!r.is_unsigned && ((f >> (fb - 1)) & 64'd1) != 0) f |= ~mask;
        if (dw == 32) f &= 64'h0000_0000_FFFF_FFFF;
        return {1'b0, f};
    endfunction

    function automatic ext_req_t rand_legal(input int dw);
        ext_req_t r;
        int sz;
        sz            = (dw == 64) ? $urandom_range(3, 0) : $urandom_range(2, 0);
        r.word        = {$urandom, $urandom};
        r.size        = ext_size_e'(sz);
        r.offset      = 3'(($urandom % ((dw / 8) >> sz)) << sz);
        r.is_unsigned = 1'($urandom);
        return r;
    endfunction

    function automatic ext_req_t rand_misaligned32();
        ext_req_t r;
        logic [64:0] e;
        do begin
            r.word        = {32'h0, $urandom};
            r.size        = ext_size_e'($urandom_range(3, 1));
            r.offset      = 3'($urandom % 4);
            r.is_unsigned = 1'($urandom);
            e             = ref_ext(r, 32);
        end while (e[64] != 1'b1);
        return r;
    endfunction

    function automatic ext_req_t mk_req(input logic [63:0] w, input int off, input ext_size_e sz,
                                        input logic uns);
        ext_req_t r;
        r.word = w; r.offset = 3'(off); r.size = sz; r.is_unsigned = uns;
        return r;
    endfunction

    task automatic drive_a(input ext_req_t r);
        a_in_valid    = 1'b1;
        a_in_word     = r.word[31:0];
        a_in_offset   = r.offset[1:0];
        a_in_size     = r.size;
        a_in_unsigned = r.is_unsigned;
    endtask

    task automatic drive_b(input ext_req_t r);
        b_in_valid    = 1'b1;
        b_in_word     = r.word;
        b_in_offset   = r.offset;
        b_in_size     = r.size;
        b_in_unsigned = r.is_unsigned;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_in_valid = 0; a_in_word = '0; a_in_offset = '0; a_in_size = '0; a_in_unsigned = 0;
        b_in_valid = 0; b_in_word = '0; b_in_offset = '0; b_in_size = '0; b_in_unsigned = 0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", a_out_valid); else passes++;
        checks++; if (a_out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", a_out_data); else passes++;
        checks++; if (a_out_misalign !== 1'b0) $display("FAIL reset_misalign got %b want 0", a_out_misalign); else passes++;
        checks++; if (a_err_count !== 8'd0) $display("FAIL reset_err_count got %0d want 0", a_err_count); else passes++;
        checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", a_in_ready); else passes++;
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_err_count !== 8'd0)
            $display("FAIL reset_dut64 got valid=%b ready=%b err=%0d want 0/1/0", b_out_valid, b_in_ready, b_err_count);
        else passes++;
        $display("txn reset done");
    endtask

    task automatic test_basic();
        logic [31:0] exp_d [4] = '{32'hFFFF_FFA5, 32'h0000_00A5, 32'hFFFF_8000, 32'h0};
        logic        exp_m [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int          offs  [4] = '{0, 0, 2, 1};
        ext_size_e   szs   [4] = '{EXT_B, EXT_B, EXT_H, EXT_H};
        logic        uns   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int          exp_e [4] = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_a(mk_req(64'h8000_F0A5, offs[i], szs[i], uns[i]));
            @(negedge clk);
            a_in_valid = 1'b0;
            $display("txn basic %0d off=%0d size=%0d uns=%b -> data=%h mis=%b err=%0d",
                     i, offs[i], szs[i], uns[i], a_out_data, a_out_misalign, a_err_count);
            checks++; if (a_out_valid !== 1'b1) $display("FAIL basic_valid[%0d] got %b want 1", i, a_out_valid); else passes++;
            checks++; if (a_out_data !== exp_d[i]) $display("FAIL basic_data[%0d] got %h want %h", i, a_out_data, exp_d[i]); else passes++;
            checks++; if (a_out_misalign !== exp_m[i]) $display("FAIL basic_mis[%0d] got %b want %b", i, a_out_misalign, exp_m[i]); else passes++;
            checks++; if (a_err_count !== 8'(exp_e[i])) $display("FAIL basic_err[%0d] got %0d want %0d", i, a_err_count, exp_e[i]); else passes++;
        end
        a_err_model = 1;
    endtask

    task automatic test_back_pressure();
        ext_req_t    r [3];
        logic [64:0] e [3];
        for (int i = 0; i < 3; i++) begin
            r[i] = rand_legal(32);
            e[i] = ref_ext(r[i], 32);
        end
        @(negedge clk);
        a_out_ready = 1'b0;
        drive_a(r[0]);
        @(negedge clk);
        checks++; if ({a_out_misalign, 32'h0, a_out_data} !== e[0]) $display("FAIL bp_first got %h want %h", a_out_data, e[0][31:0]); else passes++;
        checks++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_after1 got %b want 1", a_in_ready); else passes++;
        drive_a(r[1]);
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_ready_after2 got %b want 0", a_in_ready); else passes++;
        drive_a(r[2]);
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_ready_hold got %b want 0", a_in_ready); else passes++;
        checks++; if (a_out_valid !== 1'b1 || {a_out_misalign, 32'h0, a_out_data} !== e[0])
            $display("FAIL bp_stable got %h want %h", a_out_data, e[0][31:0]);
        else passes++;
        a_out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            $display("txn backpressure out %0d data=%h mis=%b", i, a_out_data, a_out_misalign);
            checks++; if (a_out_valid !== 1'b1 || {a_out_misalign, 32'h0, a_out_data} !== e[i])
                $display("FAIL bp_order[%0d] got v=%b %h want %h", i, a_out_valid, a_out_data, e[i][31:0]);
            else passes++;
            if (i == 1) begin
                checks++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_release got %b want 1", a_in_ready); else passes++;
            end else begin
                a_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) $display("FAIL bp_no_dup got %b want 0", a_out_valid); else passes++;
    endtask

    task automatic test_throughput();
        logic [64:0] exp_a [100];
        logic [64:0] exp_b [100];
        ext_req_t ra, rb;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            if (k > 0) begin
                $display("txn thru %0d a=%h b=%h", k - 1, a_out_data, b_out_data);
                checks++; if (a_out_valid !== 1'b1 || {a_out_misalign, 32'h0, a_out_data} !== exp_a[k-1])
                    $display("FAIL thru32[%0d] got v=%b m=%b %h want %h", k - 1, a_out_valid, a_out_misalign, a_out_data, exp_a[k-1]);
                else passes++;
                checks++; if (b_out_valid !== 1'b1 || {b_out_misalign, b_out_data} !== exp_b[k-1])
                    $display("FAIL thru64[%0d] got v=%b m=%b %h want %h", k - 1, b_out_valid, b_out_misalign, b_out_data, exp_b[k-1]);
                else passes++;
            end
            checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1)
                $display("FAIL thru_ready[%0d] got %b/%b want 1/1", k, a_in_ready, b_in_ready);
            else passes++;
            if (k < 100) begin
                ra = rand_legal(32); exp_a[k] = ref_ext(ra, 32); drive_a(ra);
                rb = rand_legal(64); exp_b[k] = ref_ext(rb, 64); drive_b(rb);
            end else begin
                a_in_valid = 1'b0;
                b_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0)
            $display("FAIL thru_drain got %b/%b want 0/0", a_out_valid, b_out_valid);
        else passes++;
    endtask

    task automatic test_dw64();
        @(negedge clk);
        drive_b(mk_req(64'h8123_4567_89AB_CDEF, 4, EXT_W, 1'b0));
        drive_a(mk_req(64'h1234_5678, 0, EXT_D, 1'b0));
        @(negedge clk);
        a_err_model++;
        $display("txn dw64 W -> %h ; dw32 D -> mis=%b", b_out_data, a_out_misalign);
        checks++; if (b_out_data !== 64'hFFFF_FFFF_8123_4567 || b_out_misalign !== 1'b0)
            $display("FAIL dw64_word got %h m=%b want ffffffff81234567", b_out_data, b_out_misalign);
        else passes++;
        checks++; if (a_out_misalign !== 1'b1 || a_out_data !== 32'h0)
            $display("FAIL dw32_dword got m=%b %h want m=1 0", a_out_misalign, a_out_data);
        else passes++;
        checks++; if (a_err_count !== 8'(a_err_model))
            $display("FAIL dw32_err got %0d want %0d", a_err_count, a_err_model);
        else passes++;
        a_in_valid = 1'b0;
        drive_b(mk_req(64'h8123_4567_89AB_CDEF, 0, EXT_D, 1'b0));
        @(negedge clk);
        b_in_valid = 1'b0;
        $display("txn dw64 D -> %h", b_out_data);
        checks++; if (b_out_data !== 64'h8123_4567_89AB_CDEF || b_out_misalign !== 1'b0)
            $display("FAIL dw64_dword got %h m=%b want 8123456789abcdef", b_out_data, b_out_misalign);
        else passes++;
    endtask

    task automatic test_saturate_and_reset();
        int base;
        int want;
        base = a_err_model;
        a_out_ready = 1'b1;
        for (int k = 0; k <= 300; k++) begin
            @(negedge clk);
            if (k > 0) begin
                want = (base + k > 255) ? 255 : base + k;
                $display("txn sat %0d err=%0d", k, a_err_count);
                checks++; if (a_out_misalign !== 1'b1 || a_out_data !== 32'h0)
                    $display("FAIL sat_out[%0d] got m=%b %h want m=1 0", k, a_out_misalign, a_out_data);
                else passes++;
                checks++; if (a_err_count !== 8'(want))
                    $display("FAIL sat_err[%0d] got %0d want %0d", k, a_err_count, want);
                else passes++;
            end
            if (k < 300) drive_a(rand_misaligned32());
            else a_in_valid = 1'b0;
        end
        // Fill output register and skid entry, then reset.
        @(negedge clk);
        a_out_ready = 1'b0;
        drive_a(rand_legal(32));
        @(negedge clk);
        drive_a(rand_legal(32));
        @(negedge clk);
        a_in_valid = 1'b0;
        checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1)
            $display("FAIL full_setup got ready=%b valid=%b want 0/1", a_in_ready, a_out_valid);
        else passes++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("txn reset-while-full valid=%b ready=%b err=%0d", a_out_valid, a_in_ready, a_err_count);
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_err_count !== 8'd0)
            $display("FAIL rst_full got valid=%b ready=%b err=%0d want 0/1/0", a_out_valid, a_in_ready, a_err_count);
        else passes++;
        a_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0)
            $display("FAIL rst_full_drop got %b want 0", a_out_valid);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_throughput();
        test_dw64();
        test_saturate_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d checks=%0d", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
